// File: rtl/m_st7789_rx.sv
// ST7789 SPI responder: deserialises the 9-bit DC+byte stream, decodes the command subset we
// use and turns RAMWR pixel pairs into framebuffer write strobes.
module m_st7789_rx #(
  parameter int unsigned IDLE_RESYNC = 64
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        st7789_SCL,
  input  logic        st7789_SDA,
  input  logic        st7789_DC,
  input  logic        st7789_RES,
  output logic        o_we,
  output logic [15:0] o_waddr,
  output logic [15:0] o_wdata,
  output logic        o_frame_done,
  output logic        o_disp_on,
  output logic        o_invert,
  output logic [7:0]  o_madctl,
  output logic [7:0]  o_colmod
);

  localparam int unsigned IdleW = $clog2(IDLE_RESYNC + 1);

  typedef enum logic [2:0] {
    StIdle, StCaset, StRaset, StParam1, StRamwrHi, StRamwrLo
  } state_e;

  logic rst;
  assign rst = !w_rst_n || !st7789_RES;

  logic             r_scl, r_sda, r_dc, r_scl_d, r_sda_d, r_dc_d;
  logic             rise;
  logic [2:0]       bit_cnt;
  logic [6:0]       shift;
  logic [IdleW-1:0] idle_cnt;
  logic             byte_v, byte_dc;
  logic [7:0]       byte_q;

  assign rise = !r_scl_d && r_scl;

  // SCL registers reset high so a released reset with SCL idling never looks like an edge.
  always_ff @(posedge w_clk) begin
    if (rst) begin
      r_scl    <= 1'b1;
      r_sda    <= 1'b0;
      r_dc     <= 1'b0;
      r_scl_d  <= 1'b1;
      r_sda_d  <= 1'b0;
      r_dc_d   <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 7'd0;
      idle_cnt <= '0;
      byte_v   <= 1'b0;
      byte_dc  <= 1'b0;
      byte_q   <= 8'd0;
    end else begin
      r_scl   <= st7789_SCL;
      r_sda   <= st7789_SDA;
      r_dc    <= st7789_DC;
      r_scl_d <= r_scl;
      r_sda_d <= r_sda;
      r_dc_d  <= r_dc;
      byte_v  <= 1'b0;
      if (rise) begin
        idle_cnt <= '0;
        shift    <= {shift[5:0], r_sda_d};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_v  <= 1'b1;
          byte_q  <= {shift, r_sda_d};
          byte_dc <= r_dc_d;
        end
      end else if (idle_cnt == IdleW'(IDLE_RESYNC)) begin
        bit_cnt <= 3'd0;
      end else begin
        idle_cnt <= idle_cnt + IdleW'(1);
      end
    end
  end

  state_e     state;
  logic [1:0] pidx;
  logic [7:0] start_lo, hi_byte;
  logic       param_sel;
  logic [7:0] xs, xe, ys, ye, x, y;

  always_ff @(posedge w_clk) begin
    if (rst) begin
      state        <= StIdle;
      pidx         <= 2'd0;
      start_lo     <= 8'd0;
      hi_byte      <= 8'd0;
      param_sel    <= 1'b0;
      xs           <= 8'd0;
      xe           <= 8'd239;
      ys           <= 8'd0;
      ye           <= 8'd239;
      x            <= 8'd0;
      y            <= 8'd0;
      o_we         <= 1'b0;
      o_waddr      <= 16'd0;
      o_wdata      <= 16'd0;
      o_frame_done <= 1'b0;
      o_disp_on    <= 1'b0;
      o_invert     <= 1'b0;
      o_madctl     <= 8'd0;
      o_colmod     <= 8'd0;
    end else begin
      o_we         <= 1'b0;
      o_frame_done <= 1'b0;
      if (byte_v && !byte_dc) begin
        state <= StIdle;
        pidx  <= 2'd0;
        case (byte_q)
          8'h2A: state <= StCaset;
          8'h2B: state <= StRaset;
          8'h2C: begin
            state <= StRamwrHi;
            x     <= xs;
            y     <= ys;
          end
          8'h36: begin
            state     <= StParam1;
            param_sel <= 1'b0;
          end
          8'h3A: begin
            state     <= StParam1;
            param_sel <= 1'b1;
          end
          8'h01: begin
            xs        <= 8'd0;
            xe        <= 8'd239;
            ys        <= 8'd0;
            ye        <= 8'd239;
            o_disp_on <= 1'b0;
            o_invert  <= 1'b0;
            o_madctl  <= 8'd0;
            o_colmod  <= 8'd0;
          end
          8'h20: o_invert  <= 1'b0;
          8'h21: o_invert  <= 1'b1;
          8'h28: o_disp_on <= 1'b0;
          8'h29: o_disp_on <= 1'b1;
          default: ;
        endcase
      end else if (byte_v) begin
        case (state)
          StCaset, StRaset: begin
            pidx <= pidx + 2'd1;
            if (pidx == 2'd1) start_lo <= byte_q;
            // Window only commits once the end low byte arrives.
            if (pidx == 2'd3) begin
              state <= StIdle;
              if (state == StCaset) begin
                xs <= start_lo;
                xe <= byte_q;
              end else begin
                ys <= start_lo;
                ye <= byte_q;
              end
            end
          end
          StParam1: begin
            state <= StIdle;
            if (param_sel) o_colmod <= byte_q;
            else           o_madctl <= byte_q;
          end
          StRamwrHi: begin
            hi_byte <= byte_q;
            state   <= StRamwrLo;
          end
          StRamwrLo: begin
            state   <= StRamwrHi;
            o_we    <= 1'b1;
            o_waddr <= {y, x};
            o_wdata <= {hi_byte, byte_q};
            if (x != xe) begin
              x <= x + 8'd1;
            end else if (y != ye) begin
              x <= xs;
              y <= y + 8'd1;
            end else begin
              x            <= xs;
              y            <= ys;
              o_frame_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_m_st7789_rx.sv
// Randomised bench for m_st7789_rx: bit-level SPI driver, high-level panel model with
// cycle-stamped expected writes/status, plus directed scenarios checked against fixed values.
module tb_m_st7789_rx;

  logic        w_clk = 1'b0;
  logic        w_rst_n, scl, sda, dc, res;
  logic        o_we, o_frame_done, o_disp_on, o_invert;
  logic [15:0] o_waddr, o_wdata;
  logic [7:0]  o_madctl, o_colmod;

  always #5 w_clk = ~w_clk;

  m_st7789_rx #(.IDLE_RESYNC(64)) dut (
    .w_clk        (w_clk),
    .w_rst_n      (w_rst_n),
    .st7789_SCL   (scl),
    .st7789_SDA   (sda),
    .st7789_DC    (dc),
    .st7789_RES   (res),
    .o_we         (o_we),
    .o_waddr      (o_waddr),
    .o_wdata      (o_wdata),
    .o_frame_done (o_frame_done),
    .o_disp_on    (o_disp_on),
    .o_invert     (o_invert),
    .o_madctl     (o_madctl),
    .o_colmod     (o_colmod)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge w_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int MIdle = 0, MCas = 1, MRas = 2, MPar = 3, MHi = 4, MLo = 5;
  int m_st = MIdle, m_pi = 0, m_sel = 0, m_hi = 0;
  int m_p[4];
  int mxs = 0, mxe = 239, mys = 0, mye = 239, mx = 0, my = 0;
  logic       m_disp = 0, m_inv = 0;
  logic [7:0] m_mad = 0, m_col = 0;

  typedef struct { int cyc; logic [15:0] addr; logic [15:0] data; logic fd; } wr_t;
  typedef struct { int cyc; logic [17:0] val; } st_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; logic fd; } log_t;
  wr_t  wq[$];
  st_t  sq[$];
  log_t wlog[$];

  task automatic push_status(input int c);
    sq.push_back('{c, {m_disp, m_inv, m_mad, m_col}});
  endtask

  task automatic model_reset();
    m_st = MIdle; m_pi = 0;
    mxs = 0; mxe = 239; mys = 0; mye = 239; mx = 0; my = 0;
    m_disp = 0; m_inv = 0; m_mad = 0; m_col = 0;
  endtask

  task automatic model_byte(input logic dcb, input logic [7:0] b, input int c);
    if (!dcb) begin
      m_st = MIdle;
      case (b)
        8'h2A: begin m_st = MCas; m_pi = 0; end
        8'h2B: begin m_st = MRas; m_pi = 0; end
        8'h2C: begin m_st = MHi; mx = mxs; my = mys; end
        8'h36: begin m_st = MPar; m_sel = 0; end
        8'h3A: begin m_st = MPar; m_sel = 1; end
        8'h01: begin
          mxs = 0; mxe = 239; mys = 0; mye = 239;
          m_disp = 0; m_inv = 0; m_mad = 0; m_col = 0;
        end
        8'h20: m_inv = 0;
        8'h21: m_inv = 1;
        8'h28: m_disp = 0;
        8'h29: m_disp = 1;
        default: ;
      endcase
    end else begin
      case (m_st)
        MCas, MRas: begin
          m_p[m_pi] = int'(b);
          m_pi++;
          if (m_pi == 4) begin
            if (m_st == MCas) begin mxs = m_p[1]; mxe = m_p[3]; end
            else begin mys = m_p[1]; mye = m_p[3]; end
            m_st = MIdle;
          end
        end
        MPar: begin
          if (m_sel == 1) m_col = b; else m_mad = b;
          m_st = MIdle;
        end
        MHi: begin m_hi = int'(b); m_st = MLo; end
        MLo: begin
          wq.push_back('{c, 16'(my * 256 + mx), 16'(m_hi * 256 + int'(b)),
                         (mx == mxe) && (my == mye)});
          if (mx != mxe) mx = (mx + 1) % 256;
          else if (my != mye) begin mx = mxs; my = (my + 1) % 256; end
          else begin mx = mxs; my = mys; end
          m_st = MHi;
        end
        default: ;
      endcase
    end
    push_status(c);
  endtask

  // ---------------- monitor ----------------
  logic        mon_en = 1'b0;
  logic [17:0] exp_st = '0;
  logic [15:0] last_addr = '0, last_data = '0;
  int          hold_clr_cyc = 32'h7fffffff;

  always @(negedge w_clk) begin
    if (mon_en) begin
      if (cyc >= hold_clr_cyc) begin
        last_addr = '0; last_data = '0; hold_clr_cyc = 32'h7fffffff;
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        exp_st = sq[0].val;
        void'(sq.pop_front());
      end
      chk("status", 32'({o_disp_on, o_invert, o_madctl, o_colmod}), 32'(exp_st));
      if (o_we) begin
        wlog.push_back('{o_waddr, o_wdata, o_frame_done});
        if (wq.size() == 0) begin
          chk("we_spurious", 32'(o_we), 32'd0);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("we_cycle", cyc, w.cyc);
          chk("waddr", 32'(o_waddr), 32'(w.addr));
          chk("wdata", 32'(o_wdata), 32'(w.data));
          chk("frame_done", 32'(o_frame_done), 32'(w.fd));
          last_addr = w.addr;
          last_data = w.data;
        end
      end else begin
        chk("frame_done_idle", 32'(o_frame_done), 32'd0);
        chk("hold", {o_waddr, o_wdata}, {last_addr, last_data});
        if (wq.size() > 0 && wq[0].cyc < cyc) begin
          chk("we_missing", 32'(o_we), 32'd1);
          void'(wq.pop_front());
        end
      end
    end
  end

  // ---------------- SPI driver ----------------
  int tb_h = 1, tb_gap = 0;

  task automatic send_bits(input logic dcb, input logic [7:0] b, input int n, output int c_last);
    c_last = 0;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge w_clk);
      scl = 1'b0; sda = b[i]; dc = dcb;
      repeat (tb_h - 1) @(negedge w_clk);
      @(negedge w_clk);
      scl = 1'b1; sda = 1'($urandom);
      c_last = cyc;
      repeat (tb_h - 1) @(negedge w_clk);
    end
  endtask

  task automatic tx(input logic dcb, input logic [7:0] b);
    int c;
    send_bits(dcb, b, 8, c);
    model_byte(dcb, b, c + 3);
    repeat (tb_gap) @(negedge w_clk);
  endtask

  task automatic do_reset(input bit use_res);
    int c;
    repeat (4) @(negedge w_clk);
    c = cyc;
    if (use_res) res = 1'b0; else w_rst_n = 1'b0;
    model_reset();
    push_status(c + 1);
    hold_clr_cyc = c + 1;
    @(negedge w_clk);
    w_rst_n = 1'b1; res = 1'b1;
  endtask

  task automatic settle();
    repeat (6) @(negedge w_clk);
  endtask

  task automatic window(input logic [7:0] cmd, input logic [7:0] s, input logic [7:0] e);
    tx(0, cmd); tx(1, 8'h00); tx(1, s); tx(1, 8'h00); tx(1, e);
  endtask

  logic [15:0] ea[7] = '{16'h140A, 16'h140B, 16'h140C, 16'h150A, 16'h150B, 16'h150C, 16'h140A};
  logic [15:0] ed[7] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'hBEEF};
  logic [7:0]  ops[7] = '{8'h20, 8'h21, 8'h28, 8'h29, 8'h11, 8'h13, 8'h01};

  initial begin
    int c, n, s, e;
    logic [7:0] pv[4];
    w_rst_n = 1'b0; res = 1'b1; scl = 1'b1; sda = 1'b0; dc = 1'b0;
    repeat (3) @(negedge w_clk);
    mon_en = 1'b1;
    w_rst_n = 1'b1;
    settle();
    chk("reset_status", 32'({o_disp_on, o_invert, o_madctl, o_colmod}), 32'd0);

    // Flags at maximum SCL rate, zero gap.
    tx(0, 8'h29); tx(0, 8'h21); settle();
    chk("disp_on", 32'(o_disp_on), 32'd1);
    chk("invert", 32'(o_invert), 32'd1);
    chk("flags_no_we", wlog.size(), 0);

    // 3x2 window plus one wrap-around pixel.
    tb_h = 2;
    window(8'h2A, 8'h0A, 8'h0C);
    window(8'h2B, 8'h14, 8'h15);
    tx(0, 8'h2C);
    for (int i = 0; i < 6; i++) begin tx(1, 8'h00); tx(1, 8'(i + 1)); end
    tx(1, 8'hBE); tx(1, 8'hEF); settle();
    chk("win_count", wlog.size(), 7);
    for (int i = 0; i < 7 && i < wlog.size(); i++) begin
      chk("win_addr", 32'(wlog[i].addr), 32'(ea[i]));
      chk("win_data", 32'(wlog[i].data), 32'(ed[i]));
      chk("win_fd", 32'(wlog[i].fd), (i == 5) ? 32'd1 : 32'd0);
    end

    // Orphaned high byte discarded by a new RAMWR.
    wlog.delete();
    tx(1, 8'hAB); tx(0, 8'h2C); tx(1, 8'h12); tx(1, 8'h34); settle();
    chk("orphan_count", wlog.size(), 1);
    if (wlog.size() > 0) begin
      chk("orphan_addr", 32'(wlog[0].addr), 32'h140A);
      chk("orphan_data", 32'(wlog[0].data), 32'h1234);
    end

    // Partial byte dropped by idle resync.
    tx(0, 8'h28); settle();
    chk("disp_off", 32'(o_disp_on), 32'd0);
    send_bits(0, 8'hFF, 5, c);
    repeat (70) @(negedge w_clk);
    tx(0, 8'h29); settle();
    chk("resync_disp_on", 32'(o_disp_on), 32'd1);

    // Mid-frame reset via w_rst_n, then via st7789_RES in the middle of a byte.
    for (int k = 0; k < 2; k++) begin
      tx(0, 8'h36); tx(1, 8'hA5); tx(0, 8'h3A); tx(1, 8'h55);
      window(8'h2A, 8'd90, 8'd200);
      window(8'h2B, 8'd50, 8'd60);
      tx(0, 8'h2C);
      for (int i = 0; i < 10; i++) begin tx(1, 8'h77); tx(1, 8'(i)); end
      if (k == 1) send_bits(1, 8'hC3, 3, c);
      do_reset(k == 1);
      settle();
      chk("rst_status", 32'({o_disp_on, o_invert, o_madctl, o_colmod}), 32'd0);
      chk("rst_we", 32'(o_we), 32'd0);
      wlog.delete();
      tb_h = 1;
      if (k == 0) begin
        tx(0, 8'h2C); tx(1, 8'h5A); tx(1, 8'hA5); settle();
        chk("rst_count", wlog.size(), 1);
        if (wlog.size() > 0) chk("rst_addr", 32'(wlog[0].addr), 32'h0000);
      end else begin
        // Last row only, so the 240-wide default x range shows in one pass.
        window(8'h2B, 8'd239, 8'd239);
        tx(0, 8'h2C);
        for (int i = 0; i < 241; i++) begin tx(1, 8'(i >> 8)); tx(1, 8'(i)); end
        settle();
        chk("row_count", wlog.size(), 241);
        if (wlog.size() == 241) begin
          chk("row_first", 32'(wlog[0].addr), 32'hEF00);
          chk("row_last", 32'(wlog[239].addr), 32'hEFEF);
          chk("row_last_fd", 32'(wlog[239].fd), 32'd1);
          chk("row_wrap", 32'(wlog[240].addr), 32'hEF00);
        end
      end
    end

    // Randomised command/pixel traffic.
    for (int it = 0; it < 120; it++) begin
      tb_h = $urandom_range(1, 3);
      tb_gap = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0, 1: begin
          tx(0, $urandom_range(0, 1) ? 8'h2A : 8'h2B);
          n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
          s = $urandom_range(0, 255);
          e = (s + $urandom_range(0, 4)) % 256;
          pv[0] = 8'($urandom); pv[1] = 8'(s); pv[2] = 8'($urandom); pv[3] = 8'(e);
          for (int i = 0; i < n; i++) tx(1, pv[i]);
        end
        2, 3, 4: begin
          tx(0, 8'h2C);
          n = $urandom_range(0, 12);
          for (int i = 0; i < n; i++) begin tx(1, 8'($urandom)); tx(1, 8'($urandom)); end
          if ($urandom_range(0, 3) == 0) tx(1, 8'($urandom));
        end
        5: begin tx(0, $urandom_range(0, 1) ? 8'h36 : 8'h3A); tx(1, 8'($urandom)); end
        6: tx(0, ops[$urandom_range(0, 6)]);
        7: tx(1, 8'($urandom));
        8: begin
          send_bits(1'($urandom), 8'($urandom), $urandom_range(1, 7), c);
          repeat (70) @(negedge w_clk);
        end
        default: do_reset(1'($urandom));
      endcase
    end

    for (int i = 0; i < 200 && (wq.size() > 0 || sq.size() > 0); i++) @(negedge w_clk);
    settle();
    chk("drain_writes", wq.size(), 0);
    chk("drain_status", sq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_st7789_rx.md
# m_st7789_rx

Responder end of the ST7789 SPI link: receives the 9-bit (DC + 8-bit MSB-first) SPI_MODE_2 stream produced by our display driver, decodes the ST7789 command subset we use, and turns RAMWR pixel bytes into framebuffer write strobes (`{y,x}` address, RGB565 data). It sits in the fabric as an in-FPGA loopback/emulator of the panel, writing a 256x256 video memory for capture, self-check and HDMI mirroring.

## Interface
- `IDLE_RESYNC`, default 64: number of `w_clk` cycles with no SCL rising edge after which a partial byte is discarded.
- `w_clk` input 1: system clock (100 MHz). SPI pins are synchronous to it.
- `w_rst_n` input 1: reset, synchronous, active-low.
- `st7789_SCL` input 1: SPI clock, idles high.
- `st7789_SDA` input 1: SPI data, MSB first.
- `st7789_DC` input 1: 0 = command byte, 1 = parameter/pixel byte.
- `st7789_RES` input 1: panel hardware reset, active-low. Same effect as `w_rst_n`.
- `o_we` output 1: one-cycle framebuffer write strobe.
- `o_waddr` output 16: `{y[7:0], x[7:0]}`.
- `o_wdata` output 16: RGB565 pixel, high byte first on the wire.
- `o_frame_done` output 1: one-cycle pulse on the write of the window's last pixel `(xe,ye)`.
- `o_disp_on` output 1: set by 0x29, cleared by 0x28 and 0x01.
- `o_invert` output 1: set by 0x21, cleared by 0x20 and 0x01.
- `o_madctl` output 8: last 0x36 parameter.
- `o_colmod` output 8: last 0x3A parameter.

## Operation
- Input stage: `r_scl`, `r_sda`, `r_dc` register the pins. `r_scl_d`, `r_sda_d`, `r_dc_d` register those. `rise = !r_scl_d && r_scl`. On `rise`, shift `r_sda_d` into the byte register. This captures data from the SCL-low half-period, because the transmitter shifts SDA on the same edge that raises SCL.
- Bit counter 0..7. On the 8th `rise`, emit a byte with DC = `r_dc_d`, then clear the counter. If the idle counter reaches `IDLE_RESYNC` with the bit counter nonzero, clear the counter and drop the partial byte.
- Decoder FSM states: IDLE, CASET(p0..p3), RASET(p0..p3), PARAM1, RAMWR_HI, RAMWR_LO.
- Any byte with DC=0 aborts the current state and dispatches on its opcode:
  - 0x2A: go to CASET.
  - 0x2B: go to RASET.
  - 0x2C: go to RAMWR_HI; set `x = xs`, `y = ys`.
  - 0x36, 0x3A: go to PARAM1.
  - 0x01: window = (0,239,0,239); clear flags, `o_madctl`, `o_colmod`; go to IDLE.
  - 0x20, 0x21, 0x28, 0x29: update the flag; go to IDLE.
  - Anything else (0x11, 0x13, ...): go to IDLE.
- DC=1 bytes in IDLE are ignored.
- CASET/RASET take 4 parameters: start_hi, start_lo, end_hi, end_lo. The window register takes the low 8 bits of each 16-bit value. It commits only when the 4th parameter arrives; an aborted sequence leaves the window unchanged.
- RAMWR: the high byte is held; on the low byte, write the pixel at `(x,y)`.
- Pixel advance after each write:
  - If `x != xe`: `x = x+1` (8-bit wrap 255→0).
  - Else if `y != ye`: `x = xs`, `y = y+1`.
  - Else: `x = xs`, `y = ys` and pulse `o_frame_done`.
- Pixel streaming continues indefinitely until the next DC=0 byte. A DC=0 byte arriving between the high and low byte discards the high byte.
- Reset values (`w_rst_n`=0 or `st7789_RES`=0, either mid-byte or mid-frame):
  - All outputs 0.
  - FSM IDLE, bit counter 0.
  - Window (0,239,0,239), `x = y = 0`.

## Timing
- Cycle T: `rise` for the 8th bit is high. The byte is valid at T+1. The FSM updates at T+1.
- For a low pixel byte completing at T: `o_we`, `o_waddr`, `o_wdata` are valid at T+2 for exactly one cycle. `o_frame_done` coincides with that `o_we`.
- Status outputs change at T+2 of their command byte.
- `o_waddr`/`o_wdata` hold their last values when `o_we`=0.
- Maximum supported SCL rate: `w_clk`/2 (one toggle per cycle). Back-to-back bytes with zero gap must be received.
- `IDLE_RESYNC` counts from the last `rise`. It never fires during a byte at the nominal rate.

## Test plan
- Drive the driver's SPI transmitter with {DC=0,0x29}, then {DC=0,0x21} → `o_disp_on`=1 and `o_invert`=1, each at T+2. No `o_we`.
- Send 0x2A 00 0A 00 0C, 0x2B 00 14 00 15, 0x2C, then 6 pixels 0x0001..0x0006 → `o_waddr` = 0x140A, 0x140B, 0x140C, 0x150A, 0x150B, 0x150C with matching data. `o_frame_done` on the 6th write only.
- Same window, 7th pixel 0xBEEF → write at 0x140A.
- After RAMWR, send high byte 0xAB, then DC=0 0x2C, then pixel 0x1234 → single write 0x1234 at `(xs,ys)`. 0xAB is never written.
- Send 5 bits, idle 64 cycles, then a full byte {DC=0,0x29} → `o_disp_on`=1. No misframe.
- Mid-frame (`x`=100, `y`=50): pulse `w_rst_n`=0 for 1 cycle (repeat with `st7789_RES`=0), then 0x2C and 1 pixel → write at 0x0000. Window restored to 0..239. All status outputs read 0.
